lsu_sram_master: RTL
====================

// Module: lsu_sram_master
// PURPOSE
//  Initiator side of the single-port sram request interface (req/wr/addr/wdata/wmask -> rdata, 1-cycle read latency).
//  Accepts one CPU load/store at a time over valid/ready. Drives a word-aligned sram access, then returns an aligned,
//  sign/zero-extended response over valid/ready. Sits between the LSU pipeline stage and the dpi_sram data port.
// PARAMETERS
//  ADDR_W   32  CPU/sram address width
//  DATA_W   32  data width; word = 4 bytes, fixed
// PORTS
//  clock         in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  cpu_valid     in   1       request valid
//  cpu_ready     out  1       request accepted when cpu_valid & cpu_ready
//  cpu_wr        in   1       1 = store, 0 = load
//  cpu_addr      in   32      byte address
//  cpu_wdata     in   32      store data, right-justified
//  cpu_size      in   2       00 byte, 01 half, 10 word, 11 treated as word
//  cpu_unsigned  in   1       loads: 1 = zero-extend, 0 = sign-extend
//  resp_valid    out  1       response valid; held until resp_ready
//  resp_ready    in   1       response consumed when resp_valid & resp_ready
//  resp_rdata    out  32      extended load data; 0 for stores
//  resp_err      out  1       misaligned access (LSU_MISALIGN_TRAP_EN only, else 0)
//  sram_req      out  1       sram access strobe, exactly one cycle per access
//  sram_wr       out  1       sram write enable
//  sram_addr     out  32      {cpu_addr[31:2],2'b00}
//  sram_wdata    out  32      store data shifted to byte lane
//  sram_wmask    out  8       byte mask; [7:4] always 0
//  sram_rdata    in   32      sram read data, valid the cycle after a read req
// BEHAVIOUR
//  Reset: state IDLE; cpu_ready=0 during reset; resp_valid=0, resp_rdata=0, resp_err=0, sram_req=0.
//  FSM IDLE -> (store) RESP; IDLE -> (load) WAIT -> RESP; RESP -> IDLE on resp_valid & resp_ready.
//  cpu_ready = (state==IDLE) & !reset. sram_* driven combinationally from cpu_* in the accept cycle T.
//  Load: sram_req at T; WAIT (T+1) registers extracted sram_rdata; resp_valid from T+2.
//  Store: sram_req & sram_wr at T; resp_valid from T+1, resp_rdata=0.
//  No new acceptance while RESP is pending; back-to-back throughput 1 access / 2 cycles (store), 3 (load).
//  Lane o = cpu_addr[1:0]: byte mask 0001<<o, half 0011<<o, word 1111; sram_wdata = cpu_wdata << 8*o.
//  Load extract: byte = rdata[8o+:8], half = rdata[8o+:16], extended to 32 per cpu_unsigned; word passthrough.
//  Reset mid-operation: FSM to IDLE, captured data discarded, no response; sram_req forced 0 while reset=1.
//  resp_rdata/resp_err stable while resp_valid=1 and resp_ready=0.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no sram_req;
//   IDLE -> RESP next cycle with resp_err=1, resp_rdata=0.
//  Undefined: resp_err tied 0; misaligned address truncated (half clears bit 0, word clears bits 1:0), access proceeds.
// STRUCTURE
//  lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W), FSM state enum, lane-mask constants.
//  Sub-module lsu_load_align: combinational lane extract + sign/zero extension (rdata, offset, size, unsigned -> data).
//  Top holds FSM, response registers, store mask/shift logic.
// TESTING
//  SW addr 0x8000_0004 data 0xDEADBEEF -> T: req=1 wr=1 addr 0x8000_0004 wmask 0x0F wdata 0xDEADBEEF; resp_valid T+1.
//  SB addr 0x8000_0003 data 0x000000A5 -> wmask 0x08, sram_wdata 0xA5000000.
//  LB addr 0x8000_0002, sram_rdata 0x12F45678, signed -> resp_rdata 0xFFFFFFF4 at T+2; LBU -> 0x000000F4.
//  LHU addr 0x8000_0002, sram_rdata 0xBEEF0000 -> 0x0000BEEF; LH -> 0xFFFFBEEF.
//  Load with resp_ready=0 for 3 cycles -> resp_valid/rdata held, cpu_ready=0, no extra sram_req.
//  LW addr 0x8000_0002: TRAP_EN -> no sram_req, resp_err=1 rdata 0; else sram_addr 0x8000_0000 load proceeds.
//  reset=1 in WAIT -> no resp_valid afterwards; cpu_ready=1 the first cycle after reset drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and byte-lane helpers for lsu_sram_master
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte lane actually used: halves drop bit 0, words always start at lane 0.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return addr_lo;
            SZ_H:    return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Size 2'b11 counts as a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - combinational load lane extract with sign/zero extension
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        data_o  = rdata_i;
        case (size_i)
            SZ_B: data_o = unsigned_i ? {24'h000000, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: data_o = unsigned_i ? {16'h0000, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_sram_master.sv
// rtl/lsu_sram_master.sv - LSU to single-port sram initiator; LSU_MISALIGN_TRAP_EN enables misalignment traps
module lsu_sram_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [7:0]        sram_wmask,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q, ld_uns_d;

    logic [1:0]        lane;
    logic [3:0]        lane_mask;
    logic              accept;
    logic              trap;
    logic [DATA_W-1:0] load_data;

    assign lane = eff_offset(cpu_size, cpu_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(cpu_size, cpu_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign cpu_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cpu_valid && cpu_ready;

    // sram side is driven straight from the CPU request in the accept cycle.
    always_comb begin
        case (cpu_size)
            SZ_B:    lane_mask = MASK_B << lane;
            SZ_H:    lane_mask = MASK_H << lane;
            default: lane_mask = MASK_W;
        endcase
    end

    assign sram_req   = accept && !trap;
    assign sram_wr    = sram_req && cpu_wr;
    assign sram_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign sram_wdata = cpu_wdata << {lane, 3'b000};
    assign sram_wmask = {4'b0000, lane_mask};

    lsu_load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .rdata_i   (sram_rdata),
        .offset_i  (ld_off_q),
        .size_i    (ld_size_q),
        .unsigned_i(ld_uns_q),
        .data_o    (load_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ld_off_d     = ld_off_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (trap) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else if (cpu_wr) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d   = ST_WAIT;
                        ld_off_d  = lane;
                        ld_size_d = cpu_size;
                        ld_uns_d  = cpu_unsigned;
                    end
                end
            end
            ST_WAIT: begin
                state_d      = ST_RESP;
                resp_rdata_d = load_data;
                resp_err_d   = 1'b0;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ld_off_q     <= 2'b00;
            ld_size_q    <= SZ_W;
            ld_uns_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ld_off_q     <= ld_off_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
